// File: rtl/pci_pkg.sv
// Shared types and constants for the PCI target controller.
package pci_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BUSY   = 3'd1,
    S_DECODE = 3'd2,
    S_DATA   = 3'd3,
    S_STOP   = 3'd4,
    S_TURN   = 3'd5
  } pci_state_e;

  localparam logic ASSERTED   = 1'b0;
  localparam logic DEASSERTED = 1'b1;

  localparam logic [1:0] DEVSEL_FAST = 2'd0;
  localparam logic [1:0] DEVSEL_MED  = 2'd1;
  localparam logic [1:0] DEVSEL_SLOW = 2'd2;

  localparam logic [3:0] CMD_MEM_RD = 4'h6;
  localparam logic [3:0] CMD_MEM_WR = 4'h7;

  localparam int unsigned RETRY_W    = 4;
  localparam logic [3:0]  RETRY_LOAD = 4'd15;

endpackage

// File: rtl/pci_devsel_timer.sv
// Loadable down-counter that parks at zero; done flag is high while the count is zero.
module pci_devsel_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         RST,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_done_c
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_done_c = (r_cnt == '0);

endmodule

// File: rtl/pci_target_ctrl.sv
// PCI slave target transaction controller: DEVSEL#/TRDY#/STOP# sequencing and burst limit.
// Optional target retry after 16 idle clocks is enabled by defining PCI_TARGET_RETRY_EN.
module pci_target_ctrl
  import pci_pkg::*;
#(
  parameter  int unsigned DEVSEL_SPEED = 1,
  parameter  int unsigned MAX_BURST    = 4,
  localparam int unsigned CNT_W        = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             frame,
  input  logic             irdy,
  input  logic             addr_hit,
  input  logic [3:0]       cmd,
  input  logic             buf_ready,
  output logic             devsel,
  output logic             trdy,
  output logic             stop,
  output logic             oe,
  output logic             xfer,
  output logic [3:0]       cmd_q,
  output logic [CNT_W-1:0] phase_cnt
);

  localparam logic [1:0] SPEED_LD =
    (DEVSEL_SPEED > 32'(DEVSEL_SLOW)) ? DEVSEL_SLOW : 2'(DEVSEL_SPEED);

  pci_state_e       r_state, w_state_nxt;
  logic             r_frame_q;
  logic             r_devsel, r_trdy, r_stop, r_oe, r_xfer;
  logic [3:0]       r_cmd_q;
  logic [CNT_W-1:0] r_phase_cnt;

  logic             w_devsel_nxt, w_trdy_nxt, w_stop_nxt, w_oe_nxt, w_xfer_nxt;
  logic [3:0]       w_cmd_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic w_addr_phase, w_claim, w_xfer, w_burst_end, w_dly_done, w_retry;

  assign w_addr_phase = (r_state == S_IDLE) && !frame && r_frame_q;
  assign w_claim      = w_addr_phase && addr_hit;
  assign w_xfer       = (r_state == S_DATA) && !irdy && (r_trdy == ASSERTED);
  assign w_burst_end  = (r_phase_cnt == CNT_W'(MAX_BURST - 1));

  pci_devsel_timer #(.W(2)) u_dly (
    .clk        (clk),
    .RST        (RST),
    .i_load     (w_claim),
    .i_load_val (SPEED_LD),
    .i_en       (r_state == S_DECODE),
    .o_done_c   (w_dly_done)
  );

`ifdef PCI_TARGET_RETRY_EN
  logic r_retry_arm;
  logic w_retry_done;

  // Retry window opens at the claiming address phase and closes at the first transfer.
  pci_devsel_timer #(.W(RETRY_W)) u_retry (
    .clk        (clk),
    .RST        (RST),
    .i_load     (w_claim),
    .i_load_val (RETRY_LOAD),
    .i_en       (1'b1),
    .o_done_c   (w_retry_done)
  );

  always_ff @(posedge clk) begin
    if (RST) begin
      r_retry_arm <= 1'b0;
    end else if (w_claim) begin
      r_retry_arm <= 1'b1;
    end else if (w_xfer || (r_state == S_IDLE)) begin
      r_retry_arm <= 1'b0;
    end
  end

  assign w_retry = r_retry_arm && w_retry_done;
`else
  assign w_retry = 1'b0;
`endif

  // Next state plus next values of the registered bus outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_devsel_nxt = r_devsel;
    w_trdy_nxt   = r_trdy;
    w_stop_nxt   = r_stop;
    w_oe_nxt     = r_oe;
    w_xfer_nxt   = 1'b0;
    w_cmd_nxt    = r_cmd_q;
    w_cnt_nxt    = r_phase_cnt;

    case (r_state)
      S_IDLE: begin
        if (w_addr_phase) begin
          if (addr_hit) begin
            w_cmd_nxt   = cmd;
            w_state_nxt = S_DECODE;
          end else begin
            w_state_nxt = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (frame && irdy) w_state_nxt = S_IDLE;
      end
      S_DECODE: begin
        if (w_dly_done) begin
          w_devsel_nxt = ASSERTED;
          w_trdy_nxt   = buf_ready ? ASSERTED : DEASSERTED;
          w_oe_nxt     = 1'b1;
          w_state_nxt  = S_DATA;
        end
      end
      S_DATA: begin
        w_devsel_nxt = ASSERTED;
        w_trdy_nxt   = buf_ready ? ASSERTED : DEASSERTED;
        if (w_xfer) begin
          w_xfer_nxt = 1'b1;
          if (r_phase_cnt < CNT_W'(MAX_BURST)) w_cnt_nxt = r_phase_cnt + CNT_W'(1);
        end
        // Turnaround outranks disconnect when both apply on the same edge.
        if ((w_xfer && frame) || (!w_xfer && frame && irdy)) begin
          w_devsel_nxt = DEASSERTED;
          w_trdy_nxt   = DEASSERTED;
          w_stop_nxt   = DEASSERTED;
          w_state_nxt  = S_TURN;
        end else if ((w_xfer && w_burst_end) || (!w_xfer && w_retry)) begin
          w_stop_nxt  = ASSERTED;
          w_trdy_nxt  = DEASSERTED;
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (frame) begin
          w_devsel_nxt = DEASSERTED;
          w_trdy_nxt   = DEASSERTED;
          w_stop_nxt   = DEASSERTED;
          w_state_nxt  = S_TURN;
        end
      end
      S_TURN: begin
        w_oe_nxt    = 1'b0;
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_frame_q   <= DEASSERTED;
      r_devsel    <= DEASSERTED;
      r_trdy      <= DEASSERTED;
      r_stop      <= DEASSERTED;
      r_oe        <= 1'b0;
      r_xfer      <= 1'b0;
      r_cmd_q     <= '0;
      r_phase_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_frame_q   <= frame;
      r_devsel    <= w_devsel_nxt;
      r_trdy      <= w_trdy_nxt;
      r_stop      <= w_stop_nxt;
      r_oe        <= w_oe_nxt;
      r_xfer      <= w_xfer_nxt;
      r_cmd_q     <= w_cmd_nxt;
      r_phase_cnt <= w_cnt_nxt;
    end
  end

  assign devsel    = r_devsel;
  assign trdy      = r_trdy;
  assign stop      = r_stop;
  assign oe        = r_oe;
  assign xfer      = r_xfer;
  assign cmd_q     = r_cmd_q;
  assign phase_cnt = r_phase_cnt;

endmodule

// File: tb/tb_pci_target_ctrl.sv
// Bench for pci_target_ctrl: three DEVSEL speeds driven in parallel against a cycle model.
module tb_pci_target_ctrl;
  import pci_pkg::*;

  localparam int MB   = 4;
  localparam int NDUT = 3;
`ifdef PCI_TARGET_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       i_rst, i_frame, i_irdy, i_hit, i_buf;
  logic [3:0] i_cmd;

  logic       d_devsel [NDUT];
  logic       d_trdy   [NDUT];
  logic       d_stop   [NDUT];
  logic       d_oe     [NDUT];
  logic       d_xfer   [NDUT];
  logic [3:0] d_cmdq   [NDUT];
  logic [2:0] d_cnt    [NDUT];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: act 0 = not involved, 1 = another target's cycle, 2 = our transaction.
  int         m_act  [NDUT] = '{0, 0, 0};
  int         m_age  [NDUT] = '{0, 0, 0};
  bit         m_turn [NDUT] = '{0, 0, 0};
  bit         m_disc [NDUT] = '{0, 0, 0};
  bit         m_xseen[NDUT] = '{0, 0, 0};
  bit         m_pf   [NDUT] = '{1, 1, 1};
  logic       m_dev  [NDUT] = '{1, 1, 1};
  logic       m_trdy [NDUT] = '{1, 1, 1};
  logic       m_stop [NDUT] = '{1, 1, 1};
  logic       m_oe   [NDUT] = '{0, 0, 0};
  logic       m_xfer [NDUT] = '{0, 0, 0};
  logic [3:0] m_cmd  [NDUT] = '{0, 0, 0};
  int         m_cnt  [NDUT] = '{0, 0, 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    pci_target_ctrl #(.DEVSEL_SPEED(g), .MAX_BURST(MB)) u_dut (
      .clk       (clk),
      .RST       (i_rst),
      .frame     (i_frame),
      .irdy      (i_irdy),
      .addr_hit  (i_hit),
      .cmd       (i_cmd),
      .buf_ready (i_buf),
      .devsel    (d_devsel[g]),
      .trdy      (d_trdy[g]),
      .stop      (d_stop[g]),
      .oe        (d_oe[g]),
      .xfer      (d_xfer[g]),
      .cmd_q     (d_cmdq[g]),
      .phase_cnt (d_cnt[g])
    );
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Target k decodes with speed k: DEVSEL# asserts at age k+1 after the address phase.
  task automatic model_step(input int k);
    bit x;
    x = 1'b0;
    if (i_rst) begin
      m_act[k] = 0; m_turn[k] = 0; m_disc[k] = 0; m_pf[k] = 1;
      m_dev[k] = 1; m_trdy[k] = 1; m_stop[k] = 1; m_oe[k] = 0;
      m_xfer[k] = 0; m_cmd[k] = 4'h0; m_cnt[k] = 0;
      return;
    end
    m_xfer[k] = 1'b0;
    if (m_act[k] == 0) begin
      if (!i_frame && m_pf[k]) begin
        if (i_hit) begin
          m_act[k] = 2; m_age[k] = 0; m_cmd[k] = i_cmd; m_xseen[k] = 0;
        end else begin
          m_act[k] = 1;
        end
      end
    end else if (m_act[k] == 1) begin
      if (i_frame && i_irdy) m_act[k] = 0;
    end else begin
      m_age[k]++;
      if (m_turn[k]) begin
        m_turn[k] = 0; m_act[k] = 0; m_oe[k] = 0; m_cnt[k] = 0;
      end else if (m_age[k] == k + 1) begin
        m_dev[k] = 0; m_oe[k] = 1; m_trdy[k] = !i_buf;
      end else if (m_age[k] > k + 1) begin
        if (m_disc[k]) begin
          if (i_frame) begin
            m_disc[k] = 0; m_turn[k] = 1; m_dev[k] = 1; m_trdy[k] = 1; m_stop[k] = 1;
          end
        end else begin
          x = !i_irdy && !m_trdy[k];
          m_trdy[k] = !i_buf;
          if (x) begin
            m_xfer[k] = 1; m_xseen[k] = 1;
            if (m_cnt[k] < MB) m_cnt[k]++;
          end
          if ((x && i_frame) || (!x && i_frame && i_irdy)) begin
            m_turn[k] = 1; m_dev[k] = 1; m_trdy[k] = 1; m_stop[k] = 1;
          end else if ((x && m_cnt[k] == MB) || (RETRY && !m_xseen[k] && m_age[k] == 16)) begin
            m_disc[k] = 1; m_stop[k] = 0; m_trdy[k] = 1;
          end
        end
      end
    end
    m_pf[k] = i_frame;
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < NDUT; k++) model_step(k);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < NDUT; k++) begin
        chk($sformatf("dut%0d devsel", k), 8'(d_devsel[k]), 8'(m_dev[k]));
        chk($sformatf("dut%0d trdy", k),   8'(d_trdy[k]),   8'(m_trdy[k]));
        chk($sformatf("dut%0d stop", k),   8'(d_stop[k]),   8'(m_stop[k]));
        chk($sformatf("dut%0d oe", k),     8'(d_oe[k]),     8'(m_oe[k]));
        chk($sformatf("dut%0d xfer", k),   8'(d_xfer[k]),   8'(m_xfer[k]));
        chk($sformatf("dut%0d cmd_q", k),  8'(d_cmdq[k]),   8'(m_cmd[k]));
        chk($sformatf("dut%0d cnt", k),    8'(d_cnt[k]),    8'(m_cnt[k]));
      end
    end
  end

  task automatic cyc(input logic f, input logic ir, input logic h, input logic b);
    i_rst = 1'b0; i_frame = f; i_irdy = ir; i_hit = h; i_buf = b;
    @(negedge clk);
  endtask

  initial begin
    int xcount;
    i_rst = 1'b1; i_frame = 1'b1; i_irdy = 1'b1; i_hit = 1'b0; i_cmd = 4'h0; i_buf = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    chk("reset devsel", 8'(d_devsel[1]), 8'd1);
    chk("reset oe", 8'(d_oe[1]), 8'd0);
    chk("reset cnt", 8'(d_cnt[1]), 8'd0);

    // Full-speed burst, disconnect after MAX_BURST phases.
    i_cmd = CMD_MEM_RD;
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    xcount = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      if (d_xfer[1] === 1'b1) xcount++;
      if (i == 1) begin
        chk("fast devsel N+1", 8'(d_devsel[0]), 8'd0);
        chk("med devsel N+1", 8'(d_devsel[1]), 8'd1);
      end
      if (i == 2) begin
        chk("med devsel N+2", 8'(d_devsel[1]), 8'd0);
        chk("slow devsel N+2", 8'(d_devsel[2]), 8'd1);
      end
      if (i == 3) chk("slow devsel N+3", 8'(d_devsel[2]), 8'd0);
    end
    chk("burst xfers", 8'(xcount), 8'd4);
    chk("cmd_q rd", 8'(d_cmdq[1]), 8'h6);
    for (int k = 0; k < NDUT; k++) begin
      chk("disc stop", 8'(d_stop[k]), 8'd0);
      chk("disc trdy", 8'(d_trdy[k]), 8'd1);
      chk("disc cnt", 8'(d_cnt[k]), 8'd4);
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("turn oe", 8'(d_oe[1]), 8'd1);
    chk("turn stop", 8'(d_stop[1]), 8'd1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("idle oe", 8'(d_oe[1]), 8'd0);
    chk("idle cnt", 8'(d_cnt[1]), 8'd0);

    // Another target's cycle: stay off the bus until frame and irdy both high.
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("busy oe", 8'(d_oe[1]), 8'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);

    // Two-phase write with buf_ready 1,0,1 and frame released on the last phase.
    i_cmd = CMD_MEM_WR;
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("wr devsel", 8'(d_devsel[1]), 8'd0);
    chk("wr trdy0", 8'(d_trdy[1]), 8'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("wr xfer1", 8'(d_xfer[1]), 8'd1);
    chk("wr trdy1", 8'(d_trdy[1]), 8'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("wr wait", 8'(d_xfer[1]), 8'd0);
    chk("wr trdy2", 8'(d_trdy[1]), 8'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("wr xfer2", 8'(d_xfer[1]), 8'd1);
    chk("wr cnt2", 8'(d_cnt[1]), 8'd2);
    chk("wr turn oe", 8'(d_oe[1]), 8'd1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("wr idle oe", 8'(d_oe[1]), 8'd0);
    chk("cmd_q wr", 8'(d_cmdq[1]), 8'h7);

    // Reset while DEVSEL# is asserted.
    i_cmd = CMD_MEM_RD;
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre-rst devsel", 8'(d_devsel[1]), 8'd0);
    i_rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      chk("rst devsel", 8'(d_devsel[k]), 8'd1);
      chk("rst trdy", 8'(d_trdy[k]), 8'd1);
      chk("rst oe", 8'(d_oe[k]), 8'd0);
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);

    // Backend never ready: retry disconnect at clock 16 only when enabled.
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 15) chk("retry stop 15", 8'(d_stop[1]), 8'd1);
      if (i == 16) begin
        chk("retry stop 16", 8'(d_stop[1]), RETRY ? 8'd0 : 8'd1);
        chk("retry cnt", 8'(d_cnt[1]), 8'd0);
      end
    end
    chk("retry stop end", 8'(d_stop[1]), RETRY ? 8'd0 : 8'd1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("final oe", 8'(d_oe[1]), 8'd0);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pci_target_ctrl.md
# pci_target_ctrl

Transaction controller for the PCI slave target. It watches `frame`/`irdy` and the address-decoder hit and sequences the active-low target control outputs `devsel`, `trdy` and `stop` with a parameterised DEVSEL decode speed. It limits bursts by disconnecting after a fixed number of data phases, and it gates the tri-state output enable for the target-driven signals. It sits between the bus pads and the slave's address decoder and data buffer.

## Interface
- `DEVSEL_SPEED`, default 1: decode delay; 0 = fast, 1 = medium, 2 = slow. Values above 2 are illegal.
- `MAX_BURST`, default 4: data phases accepted before a disconnect; 1..15.
- `clk` in 1: bus clock. All logic uses the rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `frame` in 1: bus FRAME#, active low.
- `irdy` in 1: bus IRDY#, active low.
- `addr_hit` in 1: decoder claims the address. Valid in the address-phase cycle.
- `cmd` in 4: bus C/BE# sampled in the address phase.
- `buf_ready` in 1: backend can complete a data phase in this cycle.
- `devsel` out 1: DEVSEL#, active low.
- `trdy` out 1: TRDY#, active low.
- `stop` out 1: STOP#, active low.
- `oe` out 1: drive enable for `devsel`/`trdy`/`stop` pads. When 0, the pads float (z).
- `xfer` out 1: 1-cycle strobe. A data phase completed at this edge: `irdy`==0 and `trdy`==0.
- `cmd_q` out 4: command latched at the address phase.
- `phase_cnt` out clog2(MAX_BURST+1): completed data phases in the current transaction.

## Operation
- State machine states are IDLE, BUSY, DECODE, DATA, STOP, TURN.
- **Reset:** `RST`=1 at an edge forces IDLE. It also sets `devsel`=`trdy`=`stop`=1, `oe`=0, `xfer`=0, `cmd_q`=0, `phase_cnt`=0. This applies even mid-transaction. Bus inputs are ignored while `RST`=1.
- **Address-phase detect:** the cycle where `frame`=0 and the registered previous `frame`=1, while in IDLE.
- **IDLE:**
  - Address phase with `addr_hit`=1: latch `cmd`, load the delay counter with `DEVSEL_SPEED`, go to DECODE.
  - Address phase with `addr_hit`=0: go to BUSY.
- **BUSY:** not the addressed target. Return to IDLE when `frame`=1 and `irdy`=1 are sampled together.
- **DECODE:**
  - Counter at 0: drive `devsel`=0, `oe`=1, go to DATA.
  - Otherwise decrement the counter.
- **DATA:**
  - Drive `trdy` = !`buf_ready` and `devsel`=0.
  - At an edge with `irdy`=0 and `trdy`=0: pulse `xfer` and increment `phase_cnt`.
    - If `frame`=1 (last data phase), go to TURN.
    - Else if `phase_cnt`+1 == `MAX_BURST`, go to STOP.
  - At an edge with `frame`=1 and `irdy`=1 (master abandoned the transaction), go to TURN.
- **STOP (disconnect):**
  - Drive `stop`=0, `trdy`=1, `devsel`=0.
  - Hold until `frame`=1 is sampled, then go to TURN.
- **TURN:**
  - Drive `devsel`=`trdy`=`stop`=1 with `oe`=1 for exactly one cycle.
  - Then go to IDLE with `oe`=0 and `phase_cnt` cleared.
- **Simultaneous events:** a transfer and burst exhaustion on the same edge complete the data phase first, then go to STOP. A transfer together with `frame`=1 goes to TURN; TURN takes priority over STOP.
- **Saturation:** `phase_cnt` never exceeds `MAX_BURST`.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Take edge N as the one that samples the address phase. `devsel` falls after edge N+1+`DEVSEL_SPEED`:
  - fast: low in the cycle after the address phase;
  - medium: one cycle later;
  - slow: two cycles later.
- `trdy` first falls in the same cycle as `devsel`, if `buf_ready`=1. After that it tracks `buf_ready` with one-cycle latency.
- `xfer` is high for the cycle following the transfer edge.
- Back-to-back transactions: a new address phase is recognised on the cycle after TURN returns to IDLE.

## Configuration
- `PCI_TARGET_RETRY_EN` defined:
  - A cycle counter starts at the address phase.
  - If no data phase completes within 16 clocks of it, enter STOP with `phase_cnt`=0. This is a target retry.
  - The counter stops at the first `xfer`.
- Not defined: no retry counter. The target inserts wait states indefinitely while `buf_ready`=0.

## Structure
- Shared package `pci_pkg`:
  - the state enum;
  - `ASSERTED`=1'b0 and `DEASSERTED`=1'b1;
  - DEVSEL speed constants (FAST/MED/SLOW);
  - PCI command codes (MEM_RD=4'h6, MEM_WR=4'h7).
- Sub-module `pci_devsel_timer`: a loadable down-counter with a done flag, reused by the retry counter.

## Test plan
- Reset mid-DATA (`devsel`=0) -> next cycle `devsel`=`trdy`=`stop`=1, `oe`=0, `phase_cnt`=0.
- `DEVSEL_SPEED`=0/1/2, address phase at edge N with hit -> `devsel` low after edge N+1/N+2/N+3 respectively.
- `MAX_BURST`=4, `frame`=0 held, `irdy`=0, `buf_ready`=1:
  - exactly 4 `xfer` pulses;
  - then `stop`=0 with `trdy`=1;
  - `frame` released -> one TURN cycle -> `oe`=0.
- `addr_hit`=0 -> `oe` stays 0 and BUSY is held until `frame`=`irdy`=1; a following hit transaction is claimed normally.
- `buf_ready` toggling 1,0,1 during a 2-phase burst with `frame` released on the last phase -> `trdy` follows one cycle late, `phase_cnt`=2, TURN, no `stop`.
- With `PCI_TARGET_RETRY_EN` and `buf_ready`=0 -> `stop`=0 at clock 16 after the address phase, `phase_cnt`=0. Without the macro -> no `stop`.
